// File: rtl/regfile_write_queue.sv
// regfile_write_queue
// ---------------------------------------------------------------------------
// Write-back queue in front of the 32x32-bit register file write port.
// Requests (register index + data) are accepted with a valid/ready handshake,
// held in a small in-order FIFO, and retired one per cycle onto the register
// file write port when Drain_Enable permits. Both read ports are bypassed so
// that writes still waiting in the queue are visible to readers.
//
// Ports:
//   CLK, RESET                 rising-edge clock, synchronous active-high reset
//   In_Valid / In_Ready        request handshake
//   In_Register / In_Data      request payload (index 0 requests are dropped)
//   Drain_Enable               permits retiring the head entry this cycle
//   Write_Register/Write_Data  register file write index / data
//   Reg_Write                  register file write strobe
//   Read_RegisterN             read port N index (N = 1, 2)
//   Regfile_DataN              register file read data for port N
//   Bypass_DataN               read data for port N with pending writes applied
//   Count / Empty              occupancy
// ---------------------------------------------------------------------------
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [4:0]       In_Register,
  input  logic [31:0]      In_Data,
  input  logic             Drain_Enable,
  output logic [4:0]       Write_Register,
  output logic [31:0]      Write_Data,
  output logic             Reg_Write,
  input  logic [4:0]       Read_Register1,
  input  logic [31:0]      Regfile_Data1,
  output logic [31:0]      Bypass_Data1,
  input  logic [4:0]       Read_Register2,
  input  logic [31:0]      Regfile_Data2,
  output logic [31:0]      Bypass_Data2,
  output logic [PTR_W:0]   Count,
  output logic             Empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // Entry storage. Every slot is read combinationally by the bypass logic,
  // so this stays in registers rather than a RAM.
  logic [4:0]       entry_reg_q  [DEPTH];
  logic [31:0]      entry_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             enq;
  logic             deq;

  always_comb begin
    // Ready depends on registered occupancy only: a full queue refuses a
    // request even when the head retires in the same cycle.
    In_Ready = (count_q != FULL_COUNT);
    // Index 0 requests complete the handshake but are never stored.
    enq      = In_Valid && In_Ready && (In_Register != 5'd0);
    // Nothing retires while reset is asserted.
    deq      = Drain_Enable && (count_q != '0) && !RESET;

    Reg_Write = deq;
    if (count_q != '0) begin
      Write_Register = entry_reg_q[head_q];
      Write_Data     = entry_data_q[head_q];
    end else begin
      Write_Register = 5'd0;
      Write_Data     = 32'd0;
    end

    head_d = deq ? head_q + PTR_W'(1) : head_q;
    tail_d = enq ? tail_q + PTR_W'(1) : tail_q;

    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    Count = count_q;
    Empty = (count_q == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (enq && !RESET) begin
      entry_reg_q[tail_q]  <= In_Register;
      entry_data_q[tail_q] <= In_Data;
    end
  end

  // Read bypass, one instance per read port. Entries are scanned from the
  // head (oldest) towards the tail so the last match, the youngest pending
  // write, wins. Slots beyond the current occupancy are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bypass
      logic [4:0]  rd_reg;
      logic [31:0] rf_data;
      logic [31:0] byp_data;

      assign rd_reg  = (gi == 0) ? Read_Register1 : Read_Register2;
      assign rf_data = (gi == 0) ? Regfile_Data1  : Regfile_Data2;

      always_comb begin
        byp_data = rf_data;
        for (int k = 0; k < DEPTH; k++) begin
          if (((PTR_W + 1)'(k) < count_q) && (rd_reg != 5'd0) &&
              (entry_reg_q[head_q + PTR_W'(k)] == rd_reg)) begin
            byp_data = entry_data_q[head_q + PTR_W'(k)];
          end
        end
      end
    end
  endgenerate

  assign Bypass_Data1 = g_bypass[0].byp_data;
  assign Bypass_Data2 = g_bypass[1].byp_data;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Testbench for regfile_write_queue: directed steps from the test plan followed
// by a randomized phase, all checked against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             In_Valid;
  logic             In_Ready;
  logic [4:0]       In_Register;
  logic [31:0]      In_Data;
  logic             Drain_Enable;
  logic [4:0]       Write_Register;
  logic [31:0]      Write_Data;
  logic             Reg_Write;
  logic [4:0]       Read_Register1;
  logic [31:0]      Regfile_Data1;
  logic [31:0]      Bypass_Data1;
  logic [4:0]       Read_Register2;
  logic [31:0]      Regfile_Data2;
  logic [31:0]      Bypass_Data2;
  logic [PTR_W:0]   Count;
  logic             Empty;

  always #5 CLK = ~CLK;

  regfile_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Register(In_Register), .In_Data(In_Data),
    .Drain_Enable(Drain_Enable),
    .Write_Register(Write_Register), .Write_Data(Write_Data), .Reg_Write(Reg_Write),
    .Read_Register1(Read_Register1), .Regfile_Data1(Regfile_Data1), .Bypass_Data1(Bypass_Data1),
    .Read_Register2(Read_Register2), .Regfile_Data2(Regfile_Data2), .Bypass_Data2(Bypass_Data2),
    .Count(Count), .Empty(Empty)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];          // pending writes, oldest first
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   accepted;       // handshake completed at the last edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bypass(input logic [4:0] rr, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (rr != 5'd0)
      foreach (mq[i]) if (mq[i].r == rr) v = mq[i].d;  // later entries are younger
    return v;
  endfunction

  task automatic check_outputs();
    bit exp_rw;
    exp_rw = Drain_Enable && (mq.size() != 0) && !RESET;
    chk("in_ready",  32'(In_Ready),  32'(mq.size() != DEPTH));
    chk("count",     32'(Count),     32'(mq.size()));
    chk("empty",     32'(Empty),     32'(mq.size() == 0));
    chk("reg_write", 32'(Reg_Write), 32'(exp_rw));
    if (exp_rw) begin
      chk("write_register", 32'(Write_Register), 32'(mq[0].r));
      chk("write_data",     Write_Data,          mq[0].d);
    end
    if (mq.size() == 0) begin
      chk("idle_write_register", 32'(Write_Register), 32'd0);
      chk("idle_write_data",     Write_Data,          32'd0);
    end
    chk("bypass1", Bypass_Data1, model_bypass(Read_Register1, Regfile_Data1));
    chk("bypass2", Bypass_Data2, model_bypass(Read_Register2, Regfile_Data2));
  endtask

  // Check the current cycle, clock once, and advance the model.
  task automatic step();
    bit ready, deq;
    #1;
    check_outputs();
    @(posedge CLK);
    cycle++;
    ready    = (mq.size() != DEPTH);
    deq      = Drain_Enable && (mq.size() != 0) && !RESET;
    accepted = In_Valid && ready && !RESET;
    if (RESET) begin
      mq.delete();
      $display("cycle %0d: reset", cycle);
    end else begin
      if (deq) begin
        $display("cycle %0d: retire r%0d=0x%08h", cycle, mq[0].r, mq[0].d);
        void'(mq.pop_front());
      end
      if (accepted) begin
        $display("cycle %0d: accept r%0d=0x%08h", cycle, In_Register, In_Data);
        if (In_Register != 5'd0) mq.push_back('{r: In_Register, d: In_Data});
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic dr);
    In_Valid = v; In_Register = r; In_Data = d; Drain_Enable = dr;
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    Read_Register1 = 5'd3; Regfile_Data1 = 32'hDEADBEEF;
    Read_Register2 = 5'd5; Regfile_Data2 = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(In_Ready), 32'd1);
    chk("rst_empty",    32'(Empty),    32'd1);
    chk("rst_count",    32'(Count),    32'd0);
    chk("rst_reg_write", 32'(Reg_Write), 32'd0);
    chk("rst_bypass1",  Bypass_Data1,  32'hDEADBEEF);
    step();

    // Ordered drain
    drive(1'b1, 5'd3, 32'h11, 1'b0); step();
    drive(1'b1, 5'd7, 32'h22, 1'b0); step();
    drive(1'b1, 5'd3, 32'h33, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("order_bypass_r3", Bypass_Data1, 32'h33);
    chk("order_rw0", 32'(Reg_Write), 32'd1);
    chk("order_wr0", 32'(Write_Register), 32'd3);
    chk("order_wd0", Write_Data, 32'h11);
    step();
    chk("order_wr1", 32'(Write_Register), 32'd7);
    chk("order_wd1", Write_Data, 32'h22);
    step();
    chk("order_wr2", 32'(Write_Register), 32'd3);
    chk("order_wd2", Write_Data, 32'h33);
    step();
    chk("order_empty", 32'(Empty), 32'd1);

    // Backpressure: 4 accepted, 5th held until a drain frees a slot
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 5'(n + 1), 32'h100 + 32'(n), 1'b0); step();
    end
    drive(1'b1, 5'd5, 32'h104, 1'b0);
    #1;
    chk("bp_ready_full", 32'(In_Ready), 32'd0);
    chk("bp_count_full", 32'(Count), 32'd4);
    step();
    Drain_Enable = 1'b1; step();              // full: no accept despite retiring
    chk("bp_count_after_drain", 32'(Count), 32'd3);
    chk("bp_ready_after_drain", 32'(In_Ready), 32'd1);
    Drain_Enable = 1'b0; step();
    chk("bp_fifth_accepted", 32'(accepted), 32'd1);
    chk("bp_count_refill", 32'(Count), 32'd4);

    // Drain to empty (bounded)
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    for (int n = 0; n < DEPTH + 2 && mq.size() != 0; n++) step();
    chk("drain_empty", 32'(Empty), 32'd1);

    // Register zero
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    Read_Register1 = 5'd0; Regfile_Data1 = 32'h12345678;
    #1;
    chk("r0_ready", 32'(In_Ready), 32'd1);
    step();
    chk("r0_accepted", 32'(accepted), 32'd1);
    chk("r0_count", 32'(Count), 32'd0);
    chk("r0_no_write", 32'(Reg_Write), 32'd0);
    chk("r0_bypass1", Bypass_Data1, 32'h12345678);

    // Bypass youngest-wins
    drive(1'b1, 5'd5, 32'hA, 1'b0); step();
    drive(1'b1, 5'd5, 32'hB, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    Read_Register2 = 5'd5; Regfile_Data2 = 32'h0;
    #1;
    chk("byp_youngest", Bypass_Data2, 32'hB);
    Drain_Enable = 1'b1; step(); step();
    Drain_Enable = 1'b0; Regfile_Data2 = 32'h55AA55AA;
    #1;
    chk("byp_after_drain", Bypass_Data2, 32'h55AA55AA);

    // Simultaneous enqueue/dequeue at Count=2
    drive(1'b1, 5'd9, 32'h901, 1'b0); step();
    drive(1'b1, 5'd10, 32'h902, 1'b0); step();
    drive(1'b1, 5'd11, 32'h903, 1'b1);
    #1;
    chk("sim_head_retiring_wr", 32'(Write_Register), 32'd9);
    step();
    chk("sim_count", 32'(Count), 32'd2);

    // Mid-operation reset with 3 pending entries
    drive(1'b1, 5'd12, 32'h904, 1'b0); step();
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    RESET = 1'b1;
    #1;
    chk("midrst_count_before", 32'(Count), 32'd3);
    chk("midrst_no_write", 32'(Reg_Write), 32'd0);
    step();
    RESET = 1'b0;
    #1;
    chk("midrst_count_after", 32'(Count), 32'd0);
    step();

    // Randomized phase; the upstream holds a request until it is accepted
    accepted = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (accepted || !In_Valid)
        drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, In_Valid);
      Drain_Enable   = ($urandom_range(0, 2) != 0);
      RESET          = ($urandom_range(0, 63) == 0);
      Read_Register1 = 5'($urandom_range(0, 7));
      Read_Register2 = 5'($urandom_range(0, 7));
      Regfile_Data1  = $urandom;
      Regfile_Data2  = $urandom;
      step();
    end
    RESET = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    for (int n = 0; n < DEPTH + 2; n++) step();
    chk("final_empty", 32'(Empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
